// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  // Producer source indices
  localparam int unsigned CDB_SRC_ALU     = 0;
  localparam int unsigned CDB_SRC_LSB     = 1;

  // Default entries per source queue
  localparam int unsigned CDB_QUEUE_DEPTH = 4;

  // ROB tag 0 means "no dependency" and is never broadcast
  localparam int unsigned NO_DEP_TAG      = 0;

  // Round-robin successor of grant g among n sources
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/cdb_queue.sv
// Single-source result FIFO feeding the CDB arbiter. A push into a full queue is
// accepted when the same cycle pops it; otherwise the push is dropped and flagged.
module cdb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             next_full_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full;
  logic             active;
  logic             push_ok, pop_ok;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign active  = en_i && !clr_i;
  assign pop_ok  = active && pop_i && !empty_o;
  assign push_ok = active && push_i && (!full || pop_ok);

  // Dropped push: queue full and not drained this cycle
  assign overflow_o  = active && push_i && full && !pop_ok;
  assign rdata_o     = mem_q[head_q];
  assign next_full_o = (occ_d == OCC_W'(DEPTH));

  // Next occupancy; a flush empties the queue regardless of push/pop
  always_comb begin
    occ_d = occ_q;
    if (clr_i) begin
      occ_d = '0;
    end else if (push_ok && !pop_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push_ok && pop_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (clr_i) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push_ok) tail_q <= tail_q + PTR_W'(1);
        if (pop_ok)  head_q <= head_q + PTR_W'(1);
      end
    end
  end

  // Entry storage, no reset needed since occupancy guards reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source queues served round-robin onto one
// registered broadcast bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned QUEUE_DEPTH = CDB_QUEUE_DEPTH,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy_i,
  input  logic                      clr_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_val_i,
  output logic [NUM_SRC-1:0]        src_next_full_o,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_val_o,
  output logic                      err_overflow_o
);

  localparam int unsigned ENTRY_W = TAG_W + DATA_W;
  localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [ENTRY_W-1:0] head [NUM_SRC];
  logic [NUM_SRC-1:0] empty, pop, push_req, overflow;
  logic [IDX_W-1:0]   rr_ptr_q, grant_idx;
  logic               grant_valid;
  int unsigned        cand;
  logic               cdb_valid_q, err_overflow_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_val_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Tag 0 results carry no dependency and are discarded silently
    assign push_req[i] = src_valid_i[i] &&
                         (src_tag_i[i*TAG_W +: TAG_W] != TAG_W'(NO_DEP_TAG));
    assign pop[i]      = grant_valid && (grant_idx == IDX_W'(i));

    cdb_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr_i),
      .en_i        (rdy_i),
      .push_i      (push_req[i]),
      .pop_i       (pop[i]),
      .wdata_i     ({src_tag_i[i*TAG_W +: TAG_W], src_val_i[i*DATA_W +: DATA_W]}),
      .rdata_o     (head[i]),
      .empty_o     (empty[i]),
      .next_full_o (src_next_full_o[i]),
      .overflow_o  (overflow[i])
    );
  end

  // Round-robin search: first non-empty queue starting at rr_ptr wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_SRC;
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Broadcast register and round-robin pointer; flush beats the rdy stall
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (clr_i) begin
      cdb_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (rdy_i) begin
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        {cdb_tag_q, cdb_val_q} <= head[grant_idx];
        rr_ptr_q               <= IDX_W'(rr_next(32'(grant_idx), NUM_SRC));
      end
    end
  end

  // Sticky overflow flag, survives flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_q <= 1'b0;
    end else if (|overflow) begin
      err_overflow_q <= 1'b1;
    end
  end

  assign cdb_valid_o    = cdb_valid_q;
  assign cdb_tag_o      = cdb_tag_q;
  assign cdb_val_o      = cdb_val_q;
  assign err_overflow_o = err_overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level model predicts each cycle's
// broadcast, a monitor compares it with the registered bus one edge later.
module tb_cdb_arbiter;

  localparam int NS = 2;
  localparam int D  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b0;
  logic             clr = 1'b0;
  logic [NS-1:0]    sv  = '0;
  logic [NS*TW-1:0] st  = '0;
  logic [NS*DW-1:0] sd  = '0;
  logic [NS-1:0]    snf;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_val;
  logic             err_ovf;

  cdb_arbiter #(
    .NUM_SRC     (NS),
    .QUEUE_DEPTH (D),
    .TAG_W       (TW),
    .DATA_W      (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy_i           (rdy),
    .clr_i           (clr),
    .src_valid_i     (sv),
    .src_tag_i       (st),
    .src_val_i       (sd),
    .src_next_full_o (snf),
    .cdb_valid_o     (cdb_valid),
    .cdb_tag_o       (cdb_tag),
    .cdb_val_o       (cdb_val),
    .err_overflow_o  (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
    logic          err;
  } exp_t;

  ent_t mq [NS][$];
  exp_t sb [$];
  exp_t cur = '0;
  int   rr = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts what the bus shows after this edge
  task automatic step(input logic [NS-1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic r, input logic c);
    int   g;
    ent_t e;
    logic [TW-1:0] tg [NS];
    logic [DW-1:0] dv [NS];
    tg[0] = t0; tg[1] = t1; dv[0] = d0; dv[1] = d1;
    @(negedge clk);
    rst = 1'b0; rdy = r; clr = c; sv = v; st = {t1, t0}; sd = {d1, d0};
    if (c) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      rr = 0;
      cur.v = 1'b0;
    end else if (r) begin
      g = -1;
      for (int k = 0; k < NS; k++)
        if (g < 0 && mq[(rr + k) % NS].size() > 0) g = (rr + k) % NS;
      cur.v = 1'b0;
      if (g >= 0) begin
        e = mq[g].pop_front();
        cur.v = 1'b1; cur.tag = e.tag; cur.val = e.val;
        rr = (g + 1) % NS;
      end
      for (int s = 0; s < NS; s++) begin
        if (v[s] && tg[s] != 0) begin
          if (mq[s].size() < D) mq[s].push_back('{tag: tg[s], val: dv[s]});
          else cur.err = 1'b1;
        end
      end
    end
    sb.push_back(cur);
    mon_en = 1'b1;
    #1;
    for (int s = 0; s < NS; s++)
      chk($sformatf("next_full[%0d]", s), 64'(snf[s]), 64'(!c && mq[s].size() == D));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  // Monitor: each post-reset edge yields exactly one expected bus state
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got bus update expected none queued at %0t", $time);
        end else begin
          x = sb.pop_front();
          chk("cdb", 64'({cdb_valid, cdb_tag, cdb_val, err_ovf}), 64'(x));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset cdb_tag", 64'(cdb_tag), 64'd0);
    chk("reset cdb_val", 64'(cdb_val), 64'd0);
    chk("reset err_overflow", 64'(err_ovf), 64'd0);
    chk("reset next_full", 64'(snf), 64'd0);

    // Single push, then two simultaneous pushes
    step(2'b01, 5'd3, 5'd0, 32'h11, 32'h0, 1'b1, 1'b0);
    idle(3);
    step(2'b11, 5'd2, 5'd5, 32'hA, 32'hB, 1'b1, 1'b0);
    idle(3);

    // Tag 0 from source 1 is discarded
    step(2'b10, 5'd0, 5'd0, 32'h0, 32'h99, 1'b1, 1'b0);
    idle(2);

    // Fairness and overflow: both sources push every cycle
    for (int i = 0; i < 8; i++)
      step(2'b11, 5'(8 + i), 5'(16 + i), 32'(i), 32'(100 + i), 1'b1, 1'b0);
    // Full queues drained while source 0 keeps pushing
    for (int i = 0; i < 3; i++)
      step(2'b01, 5'(24 + i), 5'd0, 32'(200 + i), 32'd0, 1'b1, 1'b0);
    idle(10);

    // Flush with entries pending
    step(2'b11, 5'd4, 5'd6, 32'h40, 32'h60, 1'b1, 1'b0);
    step(2'b01, 5'd9, 5'd0, 32'h90, 32'h0, 1'b1, 1'b0);
    step(2'b11, 5'd10, 5'd11, 32'hA0, 32'hB0, 1'b1, 1'b1);
    idle(3);

    // rdy stall while tag 7 is on the bus; pushes in the stall are ignored
    step(2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++)
      step(2'b11, 5'(12 + i), 5'(20 + i), 32'h5, 32'h6, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [TW-1:0] t0, t1;
      t0 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      t1 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(2'($urandom), t0, t1, $urandom, $urandom,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
    end
    idle(12);

    @(posedge clk);
    #2;
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter: collects result writebacks from several execution producers (ALU, LSB load path, future multiplier) and serialises them onto one registered broadcast bus consumed by RS, LSB and ROB. Each producer has a small per-source queue, so a producer never loses a result while another owns the bus. Queues are served round-robin.

## Interface
Parameters:
- NUM_SRC, 2, number of producers (source 0 = ALU, source 1 = LSB load)
- QUEUE_DEPTH, 4, entries per source queue (power of two, ≥2)
- TAG_W, 5, ROB position width; tag 0 is reserved as "no dependency"
- DATA_W, 32, result width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, all state holds and inputs are ignored
- clr  in  1  misprediction flush
- src_valid  in  NUM_SRC  result present from source i this cycle
- src_tag  in  NUM_SRC*TAG_W  ROB position of source i's result (slice i)
- src_val  in  NUM_SRC*DATA_W  result value of source i (slice i)
- src_next_full  out  NUM_SRC  queue i is full after this cycle's push/pop (combinational)
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast ROB position
- cdb_val  out  DATA_W  broadcast value
- err_overflow  out  1  sticky: a push hit a full queue and was dropped

## Operation
- Per-source FIFO: push when src_valid[i] && src_tag≠0 && (occupancy<QUEUE_DEPTH || queue i popped this cycle). Tag 0 pushes are silently discarded, with no error.
- Push to a full queue that is not popped the same cycle: the result is dropped and err_overflow is set. err_overflow clears only on rst.
- Arbitration (combinational, every rdy cycle): starting at rr_ptr, the first non-empty queue wins and its head is popped. The head entry is loaded into cdb_tag/cdb_val with cdb_valid=1 at the clock edge. If no queue is non-empty, cdb_valid<=0 and tag/val hold their values.
- rr_ptr update: after a grant to queue g, rr_ptr <= (g+1) mod NUM_SRC. rr_ptr is unchanged when there is no grant.
- Simultaneous push and pop on the same queue: both take effect and occupancy is unchanged. A full queue therefore accepts a push in the cycle it is popped.
- src_next_full[i] = (occ_i + push_i − pop_i == QUEUE_DEPTH). Same-cycle producers use it to throttle their next issue.
- clr (rdy ignored): all queues empty, rr_ptr<=0, cdb_valid<=0. Pushes in the clr cycle are discarded. err_overflow is kept.
- rst: everything cleared. Reset values: cdb_valid=0, cdb_tag=0, cdb_val=0, err_overflow=0, rr_ptr=0, all occupancies 0. src_next_full is then 0.

## Timing
- Latency: a result pushed in cycle t is on the CDB in cycle t+2 at the earliest (queue write at edge t, output register at edge t+1). There is no bypass path.
- Throughput: one broadcast per cycle in total.
- Worst-case wait of a non-empty head: NUM_SRC−1 grants.
- rdy low in cycle t: no push, no pop, and outputs hold. cdb_valid stays asserted if it was asserted; consumers are gated by rdy as well.
- Priority: rst > clr > !rdy > normal operation.

## Structure
- definition.v already defines DATA_TYPE and ROB_WRAP_POS_TYPE.
- Add the following to definition.v:
  - CDB_SRC_ALU = 0 and CDB_SRC_LSB = 1
  - CDB_QUEUE_DEPTH
  - the reserved tag constant NO_DEP_TAG = 0
- Sub-module cdb_queue holds one source FIFO: head/tail pointers, occupancy counter, and push/pop/next_full ports. It is instantiated NUM_SRC times.
- Arbiter, rr_ptr and the output register live in cdb_arbiter itself.

## Test plan
- Single push: src 0 pushes tag 3 / 0x11 in cycle 1 → cdb_valid=1, tag 3, val 0x11 in cycle 3 only. cdb_valid=0 in cycle 4.
- Simultaneous: src 0 pushes (2, 0xA) and src 1 pushes (5, 0xB) in cycle 1 with rr_ptr=0 → tag 2 in cycle 3, tag 5 in cycle 4, rr_ptr=0 afterwards.
- Fairness: both sources push every cycle for 8 cycles → CDB tags strictly alternate between sources. The first full queue shows src_next_full=1 and err_overflow is set on the next excess push.
- Full with pop: queue 0 holds 4 entries and is granted while src 0 pushes → the push is accepted, occupancy stays 4, err_overflow stays 0.
- Tag 0 and flush: src 1 pushes tag 0 → nothing is broadcast. Queues hold 3 entries and clr pulses → cdb_valid=0 next cycle, no stale tags afterwards, err_overflow unchanged.
- rdy hold: rdy=0 for 3 cycles while cdb_valid=1 with tag 7 → output is frozen. Pushes during that window never appear on the CDB, and operation resumes when rdy returns.
